// File: rtl/zjh_cnt_disp_if.sv
// Bundles the upstream count/carry inputs and the display/cascade outputs
// of zjh_cnt_disp.
//   Cin  : carry from the upstream mod-14 counter (high while its count = 13)
//   Qlo  : upstream low-digit count {Q3,Q2,Q1,Q0}
//   Qhi  : high-digit count (registered)
//   Cout : cascade carry to a further stage (combinational)
//   Seg  : segment drive {g,f,e,d,c,b,a}, active-high (registered)
//   Dig  : one-hot digit enable, bit0 = low digit, bit1 = high digit (registered)
interface zjh_cnt_disp_if;
   logic       Cin;
   logic [3:0] Qlo;
   logic [3:0] Qhi;
   logic       Cout;
   logic [6:0] Seg;
   logic [1:0] Dig;

   // master drives the counter inputs and observes the display
   modport master (output Cin, Qlo, input Qhi, Cout, Seg, Dig);
   // slave is the display/counter stage itself
   modport slave  (input Cin, Qlo, output Qhi, Cout, Seg, Dig);
endinterface : zjh_cnt_disp_if

// File: rtl/zjh_cnt_disp.sv
// High-digit counter and 2-digit multiplexed 7-segment driver placed after a
// 4-bit mod-14 counter.
//   Clk : rising-edge clock
//   MR  : asynchronous active-high reset
//   bus : zjh_cnt_disp_if.slave (Cin, Qlo in; Qhi, Cout, Seg, Dig out)
// Parameters:
//   HI_MOD   : high-digit modulus (2..16)
//   SCAN_DIV : clock cycles per digit slot (2..65535)
//   BLANK    : 1 blanks the high digit while it is 0
module zjh_cnt_disp #(
   parameter int unsigned HI_MOD   = 10,
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned BLANK    = 1
) (
   input  logic           Clk,
   input  logic           MR,
   zjh_cnt_disp_if.slave  bus
);

   localparam int unsigned QW    = 4;
   localparam int unsigned SCANW = 16;
   localparam int unsigned SEGW  = 7;

   localparam logic [QW-1:0]    HI_MAX   = QW'(HI_MOD - 1);
   localparam logic [SCANW-1:0] SCAN_MAX = SCANW'(SCAN_DIV - 1);
   localparam logic             BLANK_EN = (BLANK != 0);

   logic [QW-1:0]    qhi_q,  qhi_d;
   logic [SCANW-1:0] scan_q, scan_d;
   logic             sel_q,  sel_d;
   logic [SEGW-1:0]  seg_q,  seg_d;
   logic [1:0]       dig_q,  dig_d;
   logic             scan_wrap;

   // Hex digit to active-high {g,f,e,d,c,b,a} pattern.
   function automatic logic [SEGW-1:0] glyph(input logic [QW-1:0] v);
      logic [SEGW-1:0] g;
      case (v)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

   assign scan_wrap = (scan_q == SCAN_MAX);

   // Next-state: high-digit count, scan divider, digit select and display.
   always_comb begin
      qhi_d  = qhi_q;
      scan_d = scan_q + SCANW'(1);
      sel_d  = sel_q;
      seg_d  = glyph(bus.Qlo);
      dig_d  = 2'b01;

      if (bus.Cin) begin
         qhi_d = (qhi_q == HI_MAX) ? '0 : qhi_q + QW'(1);
      end

      if (scan_wrap) begin
         scan_d = '0;
         sel_d  = ~sel_q;
      end

      // Display uses the current (pre-increment) Qhi and sel, giving one
      // cycle of latency from both.
      if (sel_q) begin
         dig_d = 2'b10;
         seg_d = (BLANK_EN && (qhi_q == '0)) ? '0 : glyph(qhi_q);
      end
   end

   // State and output registers.
   always_ff @(posedge Clk or posedge MR) begin
      if (MR) begin
         qhi_q  <= '0;
         scan_q <= '0;
         sel_q  <= 1'b0;
         seg_q  <= '0;
         dig_q  <= '0;
      end else begin
         qhi_q  <= qhi_d;
         scan_q <= scan_d;
         sel_q  <= sel_d;
         seg_q  <= seg_d;
         dig_q  <= dig_d;
      end
   end

   // Cascade carry is combinational so a following stage increments on the
   // same edge as this one wraps.
   assign bus.Cout = bus.Cin && (qhi_q == HI_MAX);
   assign bus.Qhi  = qhi_q;
   assign bus.Seg  = seg_q;
   assign bus.Dig  = dig_q;

endmodule : zjh_cnt_disp

// File: tb/tb_zjh_cnt_disp.sv
// Directed bench for zjh_cnt_disp with default parameters. Every cycle the
// expected display/count for the coming edge is pushed to a queue and popped
// after the edge for comparison.
module tb_zjh_cnt_disp;

   localparam int TB_HI_MOD = 10;
   localparam int TB_SCAN   = 4;

   typedef struct {
      logic [6:0] seg;
      logic [1:0] dig;
      logic [3:0] qhi;
   } exp_t;

   logic Clk;
   logic MR;
   zjh_cnt_disp_if bus ();

   zjh_cnt_disp #(
      .HI_MOD  (TB_HI_MOD),
      .SCAN_DIV(TB_SCAN),
      .BLANK   (1)
   ) dut (
      .Clk(Clk),
      .MR (MR),
      .bus(bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int   errors = 0;
   int   checks = 0;
   int   n      = 0;     // edges since reset release
   int   exp_qhi = 0;    // model high digit
   exp_t sb[$];
   logic [6:0] gtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle with the given Cin; Qlo is whatever bus.Qlo holds.
   task automatic tick(input logic cin);
      exp_t e;
      exp_t got;
      logic hi;
      bus.Cin = cin;
      #1;
      chk("cout", 8'(bus.Cout), 8'(cin && (exp_qhi == TB_HI_MOD - 1)));
      hi    = ((n / TB_SCAN) % 2) == 1;
      e.dig = hi ? 2'b10 : 2'b01;
      if (hi) e.seg = (exp_qhi == 0) ? 7'h00 : gtab[exp_qhi];
      else    e.seg = gtab[bus.Qlo];
      if (cin) exp_qhi = (exp_qhi + 1) % TB_HI_MOD;
      e.qhi = 4'(exp_qhi);
      sb.push_back(e);
      n++;
      @(posedge Clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 8'd1, 8'd0);
      end else begin
         got = sb.pop_front();
         chk("seg", 8'(bus.Seg), 8'(got.seg));
         chk("dig", 8'(bus.Dig), 8'(got.dig));
         chk("qhi", 8'(bus.Qhi), 8'(got.qhi));
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_qhi"},  8'(bus.Qhi),  8'h00);
      chk({tag, "_seg"},  8'(bus.Seg),  8'h00);
      chk({tag, "_dig"},  8'(bus.Dig),  8'h00);
      chk({tag, "_cout"}, 8'(bus.Cout), 8'h00);
   endtask

   initial begin
      int cnt;
      MR      = 1'b1;
      bus.Cin = 1'b0;
      bus.Qlo = 4'd0;

      // Reset held across edges with Cin high: Cin must be ignored.
      @(posedge Clk); #1;
      bus.Cin = 1'b1;
      @(posedge Clk); #1;
      chk_reset_outputs("rst");
      bus.Cin = 1'b0;
      #4 MR = 1'b0;
      n = 0; exp_qhi = 0;

      // Reset release with Qlo=0: edge1 01/3F, edge5 10/00 (blanked).
      repeat (4) tick(1'b0);
      chk("rel_e4_seg", 8'(bus.Seg), 8'h3F);
      tick(1'b0);
      chk("rel_e5_dig", 8'(bus.Dig), 8'h02);
      chk("rel_e5_seg", 8'(bus.Seg), 8'h00);
      repeat (3) tick(1'b0);

      // Upstream mod-14 counter for 14*9 cycles: nine carries.
      cnt = 0;
      for (int i = 0; i < 14 * 9; i++) begin
         bus.Qlo = 4'(cnt);
         tick(cnt == 13);
         cnt = (cnt + 1) % 14;
      end
      chk("carry_qhi9", 8'(bus.Qhi), 8'd9);
      bus.Qlo = 4'd13;
      repeat (8) tick(1'b0);

      // Wrap and cascade carry from 9.
      bus.Qlo = 4'd0;
      bus.Cin = 1'b1;
      #1 chk("wrap_cout1", 8'(bus.Cout), 8'd1);
      tick(1'b1);
      chk("wrap_qhi0", 8'(bus.Qhi), 8'd0);
      tick(1'b0);

      // Out-of-range low counts still display E and F.
      bus.Qlo = 4'd14;
      repeat (4) tick(1'b0);
      bus.Qlo = 4'd15;
      repeat (4) tick(1'b0);

      // Glitch on Cin between edges has no effect.
      bus.Cin = 1'b1;
      #2 bus.Cin = 1'b0;
      tick(1'b0);

      // Scan period with Qlo=13, Qhi=5: 5E / 6D alternating.
      bus.Qlo = 4'd13;
      repeat (5) tick(1'b1);
      repeat (12) tick(1'b0);
      chk("scan_qhi5", 8'(bus.Qhi), 8'd5);

      // Coincidence: fresh reset, Qhi to 3, Cin on the 0->1 toggle edge.
      MR = 1'b1;
      #1 chk_reset_outputs("rst2");
      #1 MR = 1'b0;
      n = 0; exp_qhi = 0; sb.delete();
      bus.Qlo = 4'd2;
      repeat (3) tick(1'b1);
      for (int k = 0; k < 16 && ((n + 1) % 8) != 4; k++) tick(1'b0);
      tick(1'b1);
      chk("coin_qhi4", 8'(bus.Qhi), 8'd4);
      tick(1'b0);
      chk("coin_dig", 8'(bus.Dig), 8'h02);
      chk("coin_seg", 8'(bus.Seg), 8'h66);

      // Bring Qhi to 7, then pulse MR between edges.
      repeat (3) tick(1'b1);
      repeat (2) tick(1'b0);
      chk("pre_rst_qhi7", 8'(bus.Qhi), 8'd7);
      #2;
      bus.Cin = 1'b1;
      MR = 1'b1;
      #1 chk_reset_outputs("rst3");
      #1 MR = 1'b0;
      bus.Cin = 1'b0;
      n = 0; exp_qhi = 0; sb.delete();
      bus.Qlo = 4'd7;
      tick(1'b0);
      chk("post_rst_qhi0", 8'(bus.Qhi), 8'd0);
      chk("post_rst_dig", 8'(bus.Dig), 8'h01);
      chk("post_rst_seg", 8'(bus.Seg), 8'h07);
      repeat (8) tick(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_zjh_cnt_disp

// File: doc/zjh_cnt_disp.md
ZJH_CNT_DISP -- requirements
Module: zjh_cnt_disp

Purpose: downstream stage of the 4-bit mod-14 counter. Consumes its count (Q3..Q0) and carry C (asserted while count = 13), adds a high-digit counter, and drives a 2-digit multiplexed 7-segment display.

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter HI_MOD, default 10, high-digit modulus, legal range 2..16.
REQ-002 The block SHALL have parameter SCAN_DIV, default 4, Clk cycles per digit scan slot, legal range 2..65535.
REQ-003 The block SHALL have parameter BLANK, default 1; 1 blanks the high digit when it is 0.

Ports (name  direction  width  meaning):
REQ-004 Clk  input  1  single clock, rising-edge active.
REQ-005 MR  input  1  reset, asynchronous, active-high.
REQ-006 Cin  input  1  carry from the upstream counter; high for exactly the cycle the low count is 13.
REQ-007 Qlo  input  4  low-digit count from upstream, {Q3,Q2,Q1,Q0}, range 0..13.
REQ-008 Qhi  output  4  high-digit count, registered.
REQ-009 Cout  output  1  cascade carry to a further stage, combinational.
REQ-010 Seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
REQ-011 Dig  output  2  digit enable, one-hot, active-high, registered; bit0 = low digit, bit1 = high digit.

Function
REQ-012 Qhi SHALL increment on the rising Clk edge where Cin = 1, on the same edge at which the upstream counter reloads 0.
REQ-013 Qhi SHALL wrap from HI_MOD-1 to 0 on that edge, with no other wrap value.
REQ-014 Qhi SHALL hold when Cin = 0.
REQ-015 Cout SHALL equal Cin AND (Qhi == HI_MOD-1), with no register stage.
REQ-016 Scan divider scan_cnt SHALL count 0..SCAN_DIV-1 every Clk and wrap to 0.
REQ-017 Internal select sel SHALL toggle on the edge where scan_cnt = SCAN_DIV-1.
REQ-018 Each digit slot SHALL last exactly SCAN_DIV cycles.
REQ-019 Seg and Dig SHALL be registered with one cycle of latency from sel and from the digit value.
REQ-020 When sel = 0, the registered outputs SHALL be Dig = 01 and Seg = glyph(Qlo).
REQ-021 When sel = 1, the registered outputs SHALL be Dig = 10 and Seg = glyph(Qhi).
REQ-022 The glyph table SHALL map:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-023 Qlo values 14 and 15 SHALL display their glyphs (E, F) and SHALL NOT be treated as errors.
REQ-024 When BLANK = 1, sel = 1 and Qhi = 0, Seg SHALL be 00 while Dig still = 10.
REQ-025 When Cin = 1 coincides with a scan toggle, both SHALL take effect on the same edge.
REQ-026 In that case the high slot SHALL show the new Qhi one cycle later, per REQ-019.
REQ-027 Cin SHALL be sampled only on Clk edges; glitches between edges SHALL have no effect.

Reset
REQ-028 While MR = 1, the block SHALL force Qhi = 0, scan_cnt = 0, sel = 0, Seg = 00 and Dig = 00, asynchronously.
REQ-029 Cin SHALL be ignored while MR = 1.
REQ-030 Cout SHALL be 0 during reset unless Cin = 1 and HI_MOD = 1; since HI_MOD = 1 is illegal, Cout is effectively 0.
REQ-031 On the first rising edge after MR falls, the block SHALL output Dig = 01 and Seg = glyph(Qlo).
REQ-032 If MR asserts mid-scan or mid-count, the block SHALL immediately return to reset values.
REQ-033 After reset asserts mid-operation, no partial increment SHALL be retained.

Verification
REQ-034 Reset release: MR 1->0, Qlo = 0, defaults -> first edge gives Dig = 01, Seg = 3F; at edge 5 Dig = 10, Seg = 00 (blanked).
REQ-035 Carry counting: drive Cin 1 cycle in every 14, for 14*9 cycles -> Qhi steps 0..9, final Qhi = 9; high slot shows 6F.
REQ-036 Wrap and cascade: Qhi = 9, Cin = 1 -> Cout = 1 during that cycle; next edge gives Qhi = 0, Cout = 0.
REQ-037 Scan period: SCAN_DIV = 4, Qlo = 13, Qhi = 5 -> Dig alternates 01/10 every 4 cycles; Seg = 5E/6D respectively.
REQ-038 Async reset mid-operation: MR pulse between edges with Qhi = 7 -> outputs zero before the next edge; Qhi = 0 after release.
REQ-039 Coincidence: Cin = 1 on the scan-toggle edge with Qhi = 3 -> Qhi = 4; first high-slot Seg after the change = 66.
